comparator_bank_ctrl: RTL and testbench
=======================================

// Module: comparator_bank_ctrl
// PURPOSE
//  Digital companion for a bank of NCH analog comparators in the user area.
//  - Sequences each comparator's bias enable, then blanks its output for a settle time.
//  - Synchronises and debounces each raw comparator output.
//  - Raises sticky per-channel edge flags and one combined interrupt.
//  Sits between the analog comparators (VOUT pins) and the Wishbone/logic-analyzer register block.
// PARAMETERS
//  NCH          4  number of comparator channels
//  SYNC_STAGES  2  flip-flop synchroniser depth on each raw input (minimum 2)
//  DEB_W        4  width of the debounce threshold and counter
//  SETTLE_W     8  width of the settle threshold and counter
// PORTS
//  wb_clk_i      in   1           single clock domain
//  wb_rst_i      in   1           reset; synchronous, active-high
//  cmp_en_i      in   NCH         per-channel enable request
//  settle_cyc_i  in   SETTLE_W    settle (blanking) cycles after enable; shared by all channels
//  deb_cyc_i     in   DEB_W       consecutive mismatch cycles needed to accept a level change
//  edge_mode_i   in   2*NCH       per-channel edge mode {ch[i]*2+1 : ch[i]*2}
//                                 00 none, 01 rise, 10 fall, 11 both
//  cmp_vout_i    in   NCH         raw comparator outputs; asynchronous
//  irq_clr_i     in   NCH         write-1 pulse that clears the matching flag
//  cmp_pwr_en_o  out  NCH         bias/power enable to each analog comparator
//  cmp_valid_o   out  NCH         cmp_level_o is meaningful for this channel
//  cmp_level_o   out  NCH         debounced comparator level
//  irq_flag_o    out  NCH         sticky edge flags
//  irq_o         out  1           OR of irq_flag_o (combinational from flag registers)
// BEHAVIOUR
//  Reset: every register and output is 0; all FSMs enter OFF; synchronisers are flushed to 0.
//  Per-channel FSM, one per channel, all independent:
//   OFF    : pwr_en=0, valid=0, level=0, deb_cnt=0.
//            If cmp_en=1, go to SETTLE and load settle_cnt with settle_cyc_i.
//   SETTLE : pwr_en=1, valid=0. settle_cnt decrements once per cycle.
//            When settle_cnt==0, go to ACTIVE; level is seeded from the synchronised
//            input in the same cycle. settle_cyc_i=0 gives exactly 1 cycle in SETTLE.
//   ACTIVE : pwr_en=1, valid=1. Debounce and edge detection run (rules below).
//   Any state: cmp_en=0 forces OFF on the next edge, aborting a settle mid-count.
//            Flags are retained.
//  Debounce (ACTIVE only):
//   - sync!=level: deb_cnt increments.
//   - sync==level: deb_cnt clears.
//   - When deb_cnt+1 >= max(deb_cyc_i,1): level<=sync, deb_cnt<=0.
//   - Latency from a raw edge to a level change is SYNC_STAGES + max(deb_cyc_i,1) cycles.
//   - A glitch shorter than deb_cyc_i synchronised cycles is rejected.
//  Edge flags:
//   - A level flip 0->1 sets the flag when mode[0]=1; a flip 1->0 sets it when mode[1]=1.
//   - The seed at SETTLE->ACTIVE is never treated as an edge.
//   - Set and irq_clr_i in the same cycle: set wins.
//   - irq_clr_i on a clear flag has no effect.
//   - Flags survive an OFF transition; only wb_rst_i or irq_clr_i clear them.
//  Width rules: counters saturate, never wrap. Threshold inputs are sampled every cycle;
//   a change mid-count applies immediately.
// STRUCTURE
//  Shared include comparator_defs.vh holds:
//   - FSM state localparams OFF=2'd0, SETTLE=2'd1, ACTIVE=2'd2;
//   - edge mode constants EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
//  Sub-module comparator_channel contains one channel: synchroniser, FSM, debounce, flag.
//  The top instantiates it NCH times in a generate loop and ORs the flags into irq_o.
// TESTING
//  1. Reset, then cmp_en=1 with settle_cyc_i=5.
//     -> pwr_en goes high on the next edge; valid rises 6 cycles after pwr_en.
//  2. ACTIVE, deb_cyc_i=3, mode=01, raw 0->1 held high.
//     -> level=1 and flag=1 exactly 2+3 cycles after the raw edge; irq_o=1.
//  3. deb_cyc_i=3, raw high pulse lasting 2 cycles.
//     -> level stays 0 and no flag is set.
//  4. Flag set and irq_clr_i pulsed in the same cycle as a new falling edge (mode=11).
//     -> flag remains 1; a later clear alone -> 0.
//  5. cmp_en dropped during SETTLE (count 3 of 5), then re-raised.
//     -> OFF for one cycle, then a full 5-cycle settle; no edge flag on the seed.
//  6. All 4 channels with different modes and staggered edges.
//     -> only channels whose mode matches set flags; channels do not interfere.

Source files
------------

// File: rtl/comparator_bank_ctrl_pkg.sv
// ============================================================================
// Module : comparator_bank_ctrl_pkg
// Brief  : Shared channel FSM states and edge-mode encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package comparator_bank_ctrl_pkg;

    localparam logic [1:0] OFF    = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Does a level flip towards new_level qualify under this edge mode?
    function automatic logic edge_hit(input logic [1:0] mode, input logic new_level);
        if (new_level)
            return (mode & EDGE_RISE) != EDGE_NONE;
        else
            return (mode & EDGE_FALL) != EDGE_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_bank_ctrl_channel.sv
// ============================================================================
// Module : comparator_channel
// Brief  : One comparator channel: synchroniser, power/settle FSM, debounce,
//          sticky edge flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module comparator_channel
    import comparator_bank_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int SETTLE_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmp_en,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic [DEB_W-1:0]    deb_cyc,
    input  logic [1:0]          edge_mode,
    input  logic                cmp_vout,
    input  logic                irq_clr,
    output logic                pwr_en,
    output logic                valid,
    output logic                level,
    output logic                irq_flag
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [SETTLE_W-1:0]    r_settle_cnt;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic                   r_level;
    logic                   r_flag;

    logic                   w_sync;
    logic [DEB_W:0]         w_thr;
    logic [DEB_W:0]         w_cnt_inc;
    logic                   w_accept;
    logic                   w_set;

    always_ff @(posedge clk) begin
        if (rst)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], cmp_vout};
    end

    assign w_sync    = r_sync[SYNC_STAGES-1];
    // A zero threshold behaves as one so a change is always accepted eventually.
    assign w_thr     = (deb_cyc == '0) ? (DEB_W+1)'(1) : {1'b0, deb_cyc};
    assign w_cnt_inc = {1'b0, r_deb_cnt} + (DEB_W+1)'(1);
    assign w_accept  = (w_sync != r_level) && (w_cnt_inc >= w_thr);
    assign w_set     = cmp_en && (r_state == ACTIVE) && w_accept && edge_hit(edge_mode, w_sync);

    always_ff @(posedge clk) begin
        if (rst || !cmp_en) begin
            r_state      <= OFF;
            r_settle_cnt <= '0;
            r_deb_cnt    <= '0;
            r_level      <= 1'b0;
        end else begin
            case (r_state)
                OFF: begin
                    r_state      <= SETTLE;
                    r_settle_cnt <= settle_cyc;
                end
                SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state   <= ACTIVE;
                        r_level   <= w_sync;
                        r_deb_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_sync == r_level) begin
                        r_deb_cnt <= '0;
                    end else if (w_accept) begin
                        r_level   <= w_sync;
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt != '1) begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                default: r_state <= OFF;
            endcase
        end
    end

    // Flags deliberately ignore cmp_en so they survive a power-down.
    always_ff @(posedge clk) begin
        if (rst)
            r_flag <= 1'b0;
        else if (w_set)
            r_flag <= 1'b1;
        else if (irq_clr)
            r_flag <= 1'b0;
    end

    assign pwr_en   = (r_state != OFF);
    assign valid    = (r_state == ACTIVE);
    assign level    = r_level;
    assign irq_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/comparator_bank_ctrl.sv
// ============================================================================
// Module : comparator_bank_ctrl
// Brief  : Bank of NCH comparator channels with a combined edge interrupt.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module comparator_bank_ctrl
    import comparator_bank_ctrl_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int SETTLE_W    = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NCH-1:0]      cmp_en_i,
    input  logic [SETTLE_W-1:0] settle_cyc_i,
    input  logic [DEB_W-1:0]    deb_cyc_i,
    input  logic [2*NCH-1:0]    edge_mode_i,
    input  logic [NCH-1:0]      cmp_vout_i,
    input  logic [NCH-1:0]      irq_clr_i,
    output logic [NCH-1:0]      cmp_pwr_en_o,
    output logic [NCH-1:0]      cmp_valid_o,
    output logic [NCH-1:0]      cmp_level_o,
    output logic [NCH-1:0]      irq_flag_o,
    output logic                irq_o
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        comparator_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W),
            .SETTLE_W    (SETTLE_W)
        ) u_channel (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .cmp_en     (cmp_en_i[i]),
            .settle_cyc (settle_cyc_i),
            .deb_cyc    (deb_cyc_i),
            .edge_mode  (edge_mode_i[2*i +: 2]),
            .cmp_vout   (cmp_vout_i[i]),
            .irq_clr    (irq_clr_i[i]),
            .pwr_en     (cmp_pwr_en_o[i]),
            .valid      (cmp_valid_o[i]),
            .level      (cmp_level_o[i]),
            .irq_flag   (irq_flag_o[i])
        );
    end

    assign irq_o = |irq_flag_o;

endmodule

`default_nettype wire

// File: tb/tb_comparator_bank_ctrl.sv
// ============================================================================
// Module : tb_comparator_bank_ctrl
// Brief  : Directed and randomised checks of comparator_bank_ctrl against a
//          cycle-count reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_comparator_bank_ctrl;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int DW   = 4;
    localparam int SW   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en, vout, clr;
    logic [SW-1:0]    settle;
    logic [DW-1:0]    deb;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   pwr, valid, level, flag;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    comparator_bank_ctrl #(
        .NCH(NCH), .SYNC_STAGES(SYNC), .DEB_W(DW), .SETTLE_W(SW)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .cmp_en_i     (en),
        .settle_cyc_i (settle),
        .deb_cyc_i    (deb),
        .edge_mode_i  (mode),
        .cmp_vout_i   (vout),
        .irq_clr_i    (clr),
        .cmp_pwr_en_o (pwr),
        .cmp_valid_o  (valid),
        .cmp_level_o  (level),
        .irq_flag_o   (flag),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = powered down, 1 = settling, 2 = active.
    int m_ph     [NCH];
    int m_act_at [NCH];
    int m_run    [NCH];
    bit m_level  [NCH];
    bit m_flag   [NCH];
    bit m_hist   [NCH][$];
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_update();
        int thr;
        bit s, hit;
        thr = (deb == 0) ? 1 : int'(deb);
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_ph[c] = 0; m_run[c] = 0; m_level[c] = 0; m_flag[c] = 0;
                m_hist[c].delete();
                for (int k = 0; k < SYNC; k++) m_hist[c].push_back(1'b0);
                continue;
            end
            s = m_hist[c][0];
            void'(m_hist[c].pop_front());
            m_hist[c].push_back(vout[c]);
            hit = 0;
            if (!en[c]) begin
                m_ph[c] = 0; m_level[c] = 0; m_run[c] = 0;
            end else if (m_ph[c] == 0) begin
                m_ph[c] = 1;
                m_act_at[c] = cyc + int'(settle) + 1;
            end else if (m_ph[c] == 1) begin
                if (cyc == m_act_at[c]) begin
                    m_ph[c] = 2; m_level[c] = s; m_run[c] = 0;
                end
            end else if (s != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] >= thr) begin
                    hit = s ? mode[2*c] : mode[2*c+1];
                    m_level[c] = s;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            if (hit)         m_flag[c] = 1;
            else if (clr[c]) m_flag[c] = 0;
        end
        cyc++;
    endtask

    task automatic step();
        logic [NCH-1:0] ep, ev, el, ef;
        model_update();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            ep[c] = (m_ph[c] != 0);
            ev[c] = (m_ph[c] == 2);
            el[c] = m_level[c];
            ef[c] = m_flag[c];
        end
        check_eq("m_pwr",   32'(pwr),   32'(ep));
        check_eq("m_valid", 32'(valid), 32'(ev));
        check_eq("m_level", 32'(level), 32'(el));
        check_eq("m_flag",  32'(flag),  32'(ef));
        check_eq("m_irq",   32'(irq),   32'(|ef));
    endtask

    // Steps until the selected ch0 output reaches val; n is the step count (capped).
    task automatic wait_ch0(input bit use_level, input bit val, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((use_level ? level[0] : valid[0]) != val) && n < limit);
    endtask

    initial begin
        int n;
        rst = 1; en = '0; vout = '0; clr = '0; settle = '0; deb = 4'd1; mode = '0;
        repeat (3) step();
        check_eq("rst_outputs", 32'({pwr, valid, level, flag, irq}), 32'd0);
        rst = 0;
        step();

        // Power-up and settle timing
        settle = 8'd5; en = 4'b0001;
        step();
        check_eq("t1_pwr_next_edge", 32'(pwr[0]), 32'd1);
        check_eq("t1_valid_low", 32'(valid[0]), 32'd0);
        wait_ch0(1'b0, 1'b1, 20, n);
        check_eq("t1_settle_cycles", 32'(n), 32'd6);

        // Debounced rising edge latency and flag
        deb = 4'd3; mode = 8'b0000_0001; vout[0] = 1;
        wait_ch0(1'b1, 1'b1, 20, n);
        check_eq("t2_latency", 32'(n), 32'd5);
        check_eq("t2_flag", 32'(flag[0]), 32'd1);
        check_eq("t2_irq", 32'(irq), 32'd1);
        clr[0] = 1; step(); clr[0] = 0;
        check_eq("t2_clear", 32'(flag[0]), 32'd0);

        // Short glitch rejected
        vout[0] = 0; repeat (8) step();
        check_eq("t3_fall_no_flag", 32'(flag[0]), 32'd0);
        vout[0] = 1; step(); step(); vout[0] = 0;
        repeat (8) step();
        check_eq("t3_level", 32'(level[0]), 32'd0);
        check_eq("t3_flag", 32'(flag[0]), 32'd0);

        // Set beats a simultaneous clear
        mode = 8'b0000_0011; vout[0] = 1; repeat (5) step();
        check_eq("t4_rise_flag", 32'(flag[0]), 32'd1);
        vout[0] = 0; repeat (4) step();
        clr[0] = 1; step(); clr[0] = 0;
        check_eq("t4_fall_level", 32'(level[0]), 32'd0);
        check_eq("t4_set_wins", 32'(flag[0]), 32'd1);
        clr[0] = 1; step(); clr[0] = 0;
        check_eq("t4_clear_alone", 32'(flag[0]), 32'd0);

        // Abort mid-settle, then full settle; seed is not an edge
        en[0] = 0; step();
        en[0] = 1; step(); step(); step();
        vout[0] = 1; en[0] = 0; step();
        check_eq("t5_off_pwr", 32'(pwr[0]), 32'd0);
        en[0] = 1; step();
        check_eq("t5_repower", 32'(pwr[0]), 32'd1);
        wait_ch0(1'b0, 1'b1, 20, n);
        check_eq("t5_full_settle", 32'(n), 32'd6);
        check_eq("t5_seed_level", 32'(level[0]), 32'd1);
        check_eq("t5_seed_no_flag", 32'(flag[0]), 32'd0);

        // Four channels, four modes, staggered edges
        rst = 1; step(); step(); rst = 0;
        settle = '0; deb = 4'd1; en = 4'hF; vout = '0; mode = 8'b11_10_01_00;
        repeat (5) step();
        for (int i = 0; i < NCH; i++) begin vout[i] = 1; step(); end
        repeat (8) step();
        check_eq("t6_rise_flags", 32'(flag), 32'h0000_000A);
        for (int i = 0; i < NCH; i++) begin vout[i] = 0; step(); end
        repeat (8) step();
        check_eq("t6_fall_flags", 32'(flag), 32'h0000_000E);

        // Randomised traffic against the model
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 49) == 0) deb    = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) settle = SW'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) mode   = (2*NCH)'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 59) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 3) == 0)  vout[c] = ~vout[c];
                clr[c] = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
